// File: rtl/uifdma_axi_slave_mem.sv
// AXI4-full slave backed by a word-addressed memory; one write and one read burst
// in flight concurrently, every burst treated as INCR with full-width beats.
module uifdma_axi_slave_mem #(
    parameter int S_AXI_ID_WIDTH   = 1,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int S_AXI_DATA_WIDTH = 128,
    parameter int MEM_DEPTH_LOG2   = 10
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWLOCK,
    input  logic [3:0]                    S_AXI_AWCACHE,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic [3:0]                    S_AXI_AWQOS,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARLOCK,
    input  logic [3:0]                    S_AXI_ARCACHE,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic [3:0]                    S_AXI_ARQOS,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          wlast_err
);
    localparam int NB  = S_AXI_DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [S_AXI_DATA_WIDTH-1:0] mem [0:(1<<IW)-1];

    w_state_t      w_state, w_next;
    r_state_t      r_state, r_next;
    logic [IW-1:0] widx, ridx, ridx_nxt, aw_idx, ar_idx;
    logic [7:0]    wcnt, rcnt;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID  & S_AXI_WREADY;
    assign b_hs     = S_AXI_BVALID  & S_AXI_BREADY;
    assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
    assign r_hs     = S_AXI_RVALID  & S_AXI_RREADY;
    assign aw_idx   = S_AXI_AWADDR[IW+LSB-1:LSB];
    assign ar_idx   = S_AXI_ARADDR[IW+LSB-1:LSB];
    assign ridx_nxt = ridx + 1'b1;

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
                         S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                         S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
                         S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)                w_next = W_DATA;
            W_DATA:  if (w_hs && wcnt == 8'd0) w_next = W_RESP;
            W_RESP:  if (b_hs)                 w_next = W_IDLE;
            default:                           w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)                r_next = R_DATA;
            R_DATA:  if (r_hs && rcnt == 8'd0) r_next = R_IDLE;
            default:                           r_next = R_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            widx          <= '0;
            wcnt          <= '0;
            wlast_err     <= 1'b0;
        end else begin
            w_state       <= w_next;
            S_AXI_AWREADY <= (w_next == W_IDLE);
            S_AXI_WREADY  <= (w_next == W_DATA);
            S_AXI_BVALID  <= (w_next == W_RESP);
            if (aw_hs) begin
                S_AXI_BID <= S_AXI_AWID;
                widx      <= aw_idx;
                wcnt      <= S_AXI_AWLEN;
            end else if (w_hs) begin
                widx <= widx + 1'b1;
                wcnt <= wcnt - 1'b1;
                if (S_AXI_WLAST != (wcnt == 8'd0))
                    wlast_err <= 1'b1;
            end
        end
    end

    // Memory has no reset; contents survive ARESETN.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs) begin
            for (int b = 0; b < NB; b++)
                if (S_AXI_WSTRB[b])
                    mem[widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
    end

    // A fetch in the same cycle as a write to that word sees the old contents.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
            ridx          <= '0;
            rcnt          <= '0;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_IDLE);
            S_AXI_RVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                S_AXI_RID   <= S_AXI_ARID;
                ridx        <= ar_idx;
                rcnt        <= S_AXI_ARLEN;
                S_AXI_RDATA <= mem[ar_idx];
                S_AXI_RLAST <= (S_AXI_ARLEN == 8'd0);
            end else if (r_hs) begin
                if (rcnt != 8'd0) begin
                    ridx        <= ridx_nxt;
                    rcnt        <= rcnt - 1'b1;
                    S_AXI_RDATA <= mem[ridx_nxt];
                    S_AXI_RLAST <= (rcnt == 8'd1);
                end else begin
                    S_AXI_RLAST <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uifdma_axi_slave_mem.sv
// Directed bench for uifdma_axi_slave_mem: bursts, strobes, wrap, backpressure,
// WLAST mismatch and mid-burst reset, checked against a byte-strobe memory model.
module tb_uifdma_axi_slave_mem;
    localparam int DW = 128, NB = 16, DEPTH = 1024;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          awid = 0, awvalid = 0, wlast = 0, wvalid = 0, bready = 0;
    logic [31:0]   awaddr = 0, araddr = 0;
    logic [7:0]    awlen = 0, arlen = 0;
    logic [DW-1:0] wdata = 0;
    logic [NB-1:0] wstrb = 0;
    logic          arid = 0, arvalid = 0, rready = 0;
    logic          awready, wready, bid, bvalid, arready, rid, rlast, rvalid, wlast_err;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    uifdma_axi_slave_mem dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(3'd4), .S_AXI_AWBURST(2'b01), .S_AXI_AWLOCK(1'b0),
        .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(3'd4), .S_AXI_ARBURST(2'b01), .S_AXI_ARLOCK(1'b0),
        .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .wlast_err(wlast_err)
    );

    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] mdl  [0:DEPTH-1];
    logic [DW-1:0] wbuf [0:255];
    logic [NB-1:0] sbuf [0:255];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic id, input logic [31:0] addr, input int len,
                            input int wlast_at, input bit rnd);
        int idx, cyc, wi;
        bit done;
        idx = int'((addr >> 4) % DEPTH);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 2000) begin @(negedge clk); cyc++; end
        if (!awready) begin chk("aw_hs", awready, 1'b1); awvalid = 1'b0; return; end
        @(negedge clk);
        awvalid = 1'b0;
        chk("awready_low_in_burst", awready, 1'b0);
        chk("wready_after_aw", wready, 1'b1);
        for (int k = 0; k <= len; k++) begin
            wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == wlast_at);
            done = 1'b0; cyc = 0;
            while (!done && cyc < 2000) begin
                wvalid = rnd ? ($urandom_range(3) != 0) : 1'b1;
                if (wvalid && wready) done = 1'b1;
                @(negedge clk); cyc++;
            end
            if (!done) begin chk($sformatf("w_beat%0d_hs", k), done, 1'b1); wvalid = 1'b0; return; end
            wi = (idx + k) % DEPTH;
            for (int b = 0; b < NB; b++)
                if (sbuf[k][b]) mdl[wi][8*b +: 8] = wbuf[k][8*b +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_after_last_w", bvalid, 1'b1);
        chk("wready_after_last_w", wready, 1'b0);
        done = 1'b0; cyc = 0;
        while (!done && cyc < 2000) begin
            bready = rnd ? ($urandom_range(1) != 0) : 1'b1;
            if (bvalid && bready) begin
                chk("bid", bid, id);
                chk("bresp", bresp, 2'b00);
                done = 1'b1;
            end
            @(negedge clk); cyc++;
        end
        bready = 1'b0;
        if (!done) chk("b_hs", done, 1'b1);
        chk("awready_after_b", awready, 1'b1);
    endtask

    task automatic do_read(input logic id, input logic [31:0] addr, input int len, input bit rnd);
        int idx, cyc, k;
        bit stalled;
        logic [DW-1:0] sv;
        idx = int'((addr >> 4) % DEPTH);
        @(negedge clk);
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 2000) begin @(negedge clk); cyc++; end
        if (!arready) begin chk("ar_hs", arready, 1'b1); arvalid = 1'b0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_after_ar", rvalid, 1'b1);
        chk("arready_low_in_burst", arready, 1'b0);
        k = 0; cyc = 0; stalled = 1'b0; sv = '0;
        while (k <= len && cyc < 4000) begin
            if (stalled) chk($sformatf("rdata_hold%0d", k), rdata, sv);
            rready = rnd ? ($urandom_range(2) != 0) : 1'b1;
            if (rvalid && rready) begin
                chk($sformatf("rdata%0d", k), rdata, mdl[(idx + k) % DEPTH]);
                chk($sformatf("rlast%0d", k), rlast, (k == len));
                chk($sformatf("rid%0d", k), rid, id);
                chk($sformatf("rresp%0d", k), rresp, 2'b00);
                k++; stalled = 1'b0;
            end else begin
                stalled = rvalid; sv = rdata;
            end
            @(negedge clk); cyc++;
        end
        rready = 1'b0;
        if (k <= len) begin chk("r_beats_done", k, len + 1); return; end
        chk("rvalid_after_last_r", rvalid, 1'b0);
        chk("arready_after_last_r", arready, 1'b1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_resp", {bresp, rresp}, 4'h0);
        chk("rst_ids", {bid, rid}, 2'b00);
        chk("rst_rdata", rdata, '0);
        chk("rst_wlast_err", wlast_err, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("awready_after_rst", awready, 1'b1);
        chk("arready_after_rst", arready, 1'b1);

        // basic burst at 0x100
        for (int k = 0; k < 4; k++) begin wbuf[k] = DW'(8'hA0 + k); sbuf[k] = '1; end
        do_write(1'b1, 32'h100, 3, 3, 1'b0);
        do_read(1'b0, 32'h100, 3, 1'b0);
        chk("wlast_err_clean", wlast_err, 1'b0);

        // partial strobes over an all-ones word
        wbuf[0] = '1; sbuf[0] = '1;
        do_write(1'b0, 32'h2000, 0, 0, 1'b0);
        wbuf[0] = '0; sbuf[0] = 16'h00FF;
        do_write(1'b0, 32'h2000, 0, 0, 1'b0);
        do_read(1'b1, 32'h2000, 0, 1'b0);

        // 256 beats from index 1020, wrapping; upper and low address bits ignored
        for (int k = 0; k < 256; k++) begin
            wbuf[k] = {32'hDEADBEEF, 32'(k), 32'(k * 7), 32'hC0DE0000 + 32'(k)};
            sbuf[k] = '1;
        end
        do_write(1'b1, 32'h8000_3FC5, 255, 255, 1'b0);
        do_read(1'b1, 32'h0000_3FC0, 255, 1'b0);

        // concurrent randomised bursts on disjoint regions
        for (int k = 0; k < 256; k++) begin
            wbuf[k] = {32'(k), 32'h5A5A0000 ^ 32'(k * 13), 64'h0123_4567_89AB_CDEF + 64'(k)};
            sbuf[k] = '1;
        end
        fork
            do_write(1'b0, 32'h3000, 255, 255, 1'b1);
            do_read(1'b1, 32'h0, 251, 1'b1);
        join
        do_read(1'b0, 32'h3000, 255, 1'b1);

        // early WLAST: all four beats still land
        for (int k = 0; k < 4; k++) begin wbuf[k] = DW'(32'h7700 + k); sbuf[k] = '1; end
        do_write(1'b1, 32'h5000, 3, 1, 1'b0);
        chk("wlast_err_set", wlast_err, 1'b1);
        do_read(1'b0, 32'h5000, 3, 1'b0);
        chk("wlast_err_sticky", wlast_err, 1'b1);

        // reset in the middle of an 8-beat read
        @(negedge clk);
        arid = 1'b1; araddr = 32'h0; arlen = 8'd7; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rdata2", rdata, mdl[2]);
        rst_n = 1'b0; rready = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_rlast", rlast, 1'b0);
        chk("mid_rst_arready", arready, 1'b0);
        chk("mid_rst_wlast_err", wlast_err, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("arready_before_edge", arready, 1'b0);
        @(negedge clk);
        chk("arready_one_edge", arready, 1'b1);
        chk("rvalid_after_release", rvalid, 1'b0);
        do_read(1'b0, 32'h0, 7, 1'b0);
        do_read(1'b1, 32'h5000, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
